sequence_checker: RTL
=====================

Name: sequence_checker

Overview:
- Sequential replacement for the single-entry combinational player-input check in the Simon Says game.
- Walks a stored colour sequence entry by entry and waits for each player press and release.
- One-hot button presses are encoded and compared against the current sequence entry.
- Reports a single-cycle pass or fail (with cause) to the game FSM. Sits between the button synchroniser and the game FSM, and is parametrised in button count, sequence depth and press timeout.

Parameters:
- NUM_BUTTONS, 4, number of player buttons; code width CODE_W = $clog2(NUM_BUTTONS)+1, MSB of each entry = empty flag
- MAX_LEN, 32, sequence depth in entries; IDX_W = $clog2(MAX_LEN)
- TIMEOUT_CYCLES, 50000000, clock cycles allowed between entering WAIT_PRESS and a press; 0 disables timeout

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- seq  input  [MAX_LEN-1:0][CODE_W-1:0]  stored sequence; entry[CODE_W-1]=1 marks empty, low bits = button code
- round_len  input  IDX_W+1  entries to check this round, sampled on accepted start
- start  input  1  begin checking, accepted only in IDLE
- buttons  input  NUM_BUTTONS  synchronised, debounced button levels, 1 = pressed
- busy  output  1  high in any state other than IDLE
- check_idx  output  IDX_W  index of entry currently expected
- pass  output  1  one-cycle pulse: whole round matched
- fail  output  1  one-cycle pulse: round failed
- fail_code  output  2  cause, valid with fail and held until the next accepted start: 01 wrong button, 10 multiple buttons, 11 timeout

Behaviour:
- One clock, clk; reset is synchronous and active-high. Reset forces state IDLE and clears busy, check_idx, pass, fail, fail_code and the timer, including mid-round.
- Encoding: buttons one-hot with bit i set gives code i (e.g. 4'b1000 gives 3). All-zero means no press. More than one bit set means multi-press.
- Match condition: entry seq[check_idx] is not empty AND its low CODE_W-1 bits equal the encoded code.
- Effective length is L = min(round_len, MAX_LEN), further cut to the index of the first empty entry.
- States:
  - IDLE:
    - Start accepted: latch round_len, check_idx=0, timer=0.
    - L==0: pass pulse next cycle, stay IDLE.
    - Otherwise go to WAIT_PRESS.
  - WAIT_PRESS:
    - buttons==0: timer increments.
    - Timer reaches TIMEOUT_CYCLES-1 (when nonzero): go to DONE_FAIL with code 11.
    - Multi-press: go to DONE_FAIL with code 10. Multi-press takes priority over timeout.
    - Single press with match: go to WAIT_RELEASE.
    - Single press with mismatch: go to DONE_FAIL with code 01.
  - WAIT_RELEASE:
    - No timeout. Further bits asserted while held are ignored.
    - buttons==0: if check_idx+1==L, go to DONE_PASS. Otherwise increment check_idx, clear timer and go to WAIT_PRESS.
  - DONE_PASS: pass=1 for exactly one cycle, then IDLE.
  - DONE_FAIL: fail=1 for exactly one cycle, then IDLE.
- Latency: the offending or final sample in cycle N gives state DONE_* in N+1, with pass/fail registered high during N+1.
- start asserted while busy is ignored.
- seq must be stable while busy. It is sampled combinationally at check_idx.
- pass and fail are never high together.
- fail_code is cleared to 00 on an accepted start.
- Buttons already held when start is accepted: a press is evaluated in the first WAIT_PRESS cycle, so the player is not forced to release first.
- The timer saturates and does not wrap. The timeout counter width is $clog2(TIMEOUT_CYCLES+1).

Test Plan (NUM_BUTTONS=4, MAX_LEN=32, TIMEOUT_CYCLES=16):
- Full pass:
  - Stimulus: seq = {0:3, 1:0, 2:2}, round_len=3, start. Press/release 1000, 0001, 0100, with 2 idle cycles each.
  - Required: check_idx steps 0→1→2; pass pulses once, in the cycle after the final release; fail stays 0; busy drops with the pass.
- Wrong button:
  - Stimulus: seq[0]=code 1, press 0100.
  - Required: fail=1 one cycle later, fail_code=01, check_idx=0, then IDLE.
- Multi-press and timeout:
  - Multi-press: press 0011 → fail_code=10.
  - Timeout: separate run with no press for 16 cycles → fail_code=11 and fail in cycle 17 after entering WAIT_PRESS.
- Early-end and zero-length rounds:
  - Stimulus: seq[2] empty, round_len=5, correct presses for entries 0 and 1.
  - Required: pass after 2 entries.
  - Also: round_len=0 → pass one cycle after start, with no presses needed.
- Reset and protocol edges:
  - Assert reset while in WAIT_RELEASE at check_idx=4 → all outputs 0 and IDLE next cycle.
  - start while busy → no effect on check_idx.
  - Holding the button across two entries does not advance past one entry.

Source files
------------

// File: rtl/sequence_checker.sv
// Walks a stored Simon Says colour sequence, comparing each one-hot button press to the current entry.
// Result latency: one cycle after the deciding sample; pass/fail are registered single-cycle pulses.
// No backpressure: start is ignored while busy, seq must stay stable until the round ends.
module sequence_checker #(
    parameter  int NUM_BUTTONS    = 4,
    parameter  int MAX_LEN        = 32,
    parameter  int TIMEOUT_CYCLES = 50000000,
    localparam int CODE_W         = $clog2(NUM_BUTTONS) + 1,
    localparam int IDX_W          = $clog2(MAX_LEN)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [MAX_LEN-1:0][CODE_W-1:0]   seq,
    input  logic [IDX_W:0]                   round_len,
    input  logic                             start,
    input  logic [NUM_BUTTONS-1:0]           buttons,
    output logic                             busy,
    output logic [IDX_W-1:0]                 check_idx,
    output logic                             pass,
    output logic                             fail,
    output logic [1:0]                       fail_code
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IDX_W:0]   MAX_LEN_L = (IDX_W+1)'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_PRESS,
        S_WAIT_RELEASE,
        S_DONE_PASS,
        S_DONE_FAIL
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  check_idx_q, check_idx_d;
    logic [IDX_W:0]    round_len_q, round_len_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic [1:0]        fail_code_q, fail_code_d;

    logic [CODE_W-2:0] btn_code;
    logic              btn_any;
    logic              btn_multi;
    logic [IDX_W:0]    len_sel;
    logic [IDX_W:0]    first_empty;
    logic [IDX_W:0]    eff_len;
    logic [CODE_W-1:0] entry;
    logic              entry_match;
    logic              last_entry;

    always_comb begin
        btn_code = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (buttons[i]) btn_code = btn_code | (CODE_W-1)'(i);
        end
        btn_any   = |buttons;
        btn_multi = |(buttons & (buttons - NUM_BUTTONS'(1)));
    end

    // In IDLE the round length has not been latched yet, so a zero-length
    // round must be detected from the live input on the accepting edge.
    always_comb begin
        len_sel     = (state_q == S_IDLE) ? round_len : round_len_q;
        first_empty = MAX_LEN_L;
        for (int i = MAX_LEN - 1; i >= 0; i--) begin
            if (seq[i][CODE_W-1]) first_empty = (IDX_W+1)'(i);
        end
        eff_len = len_sel;
        if (eff_len > MAX_LEN_L)   eff_len = MAX_LEN_L;
        if (first_empty < eff_len) eff_len = first_empty;
    end

    always_comb begin
        entry       = seq[check_idx_q];
        entry_match = !entry[CODE_W-1] && (entry[CODE_W-2:0] == btn_code);
        last_entry  = ({1'b0, check_idx_q} + (IDX_W+1)'(1)) == eff_len;
    end

    always_comb begin
        state_d     = state_q;
        check_idx_d = check_idx_q;
        round_len_d = round_len_q;
        timer_d     = timer_q;
        pass_d      = 1'b0;
        fail_d      = 1'b0;
        fail_code_d = fail_code_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    round_len_d = round_len;
                    check_idx_d = '0;
                    timer_d     = '0;
                    fail_code_d = 2'b00;
                    if (eff_len == '0) pass_d  = 1'b1;
                    else               state_d = S_WAIT_PRESS;
                end
            end
            S_WAIT_PRESS: begin
                if (!btn_any) begin
                    if ((TIMEOUT_CYCLES != 0) && (timer_q == TMR_LAST)) begin
                        state_d     = S_DONE_FAIL;
                        fail_d      = 1'b1;
                        fail_code_d = 2'b11;
                    end else if (timer_q != '1) begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end else if (btn_multi) begin
                    state_d     = S_DONE_FAIL;
                    fail_d      = 1'b1;
                    fail_code_d = 2'b10;
                end else if (entry_match) begin
                    state_d = S_WAIT_RELEASE;
                end else begin
                    state_d     = S_DONE_FAIL;
                    fail_d      = 1'b1;
                    fail_code_d = 2'b01;
                end
            end
            S_WAIT_RELEASE: begin
                if (!btn_any) begin
                    if (last_entry) begin
                        state_d = S_DONE_PASS;
                        pass_d  = 1'b1;
                    end else begin
                        check_idx_d = check_idx_q + IDX_W'(1);
                        timer_d     = '0;
                        state_d     = S_WAIT_PRESS;
                    end
                end
            end
            S_DONE_PASS: state_d = S_IDLE;
            S_DONE_FAIL: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            check_idx_q <= '0;
            round_len_q <= '0;
            timer_q     <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            check_idx_q <= check_idx_d;
            round_len_q <= round_len_d;
            timer_q     <= timer_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            fail_code_q <= fail_code_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign check_idx = check_idx_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;

endmodule
